// File: rtl/row_renderer_p.sv
// Per-scanline entity renderer: on each swap it advances the display row, optionally
// clears the row buffer, then draws the covering span of every visible entity.
module row_renderer_p #(
  parameter int          ENT_DIM   = 48,
  parameter int          MAX_ROW   = 480,
  parameter int          ROW_WIDTH = 640,
  parameter int          COORD_W   = 10,
  parameter int          ENT_AW    = 8,
  parameter bit          CLEAR_EN  = 1'b1,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     swap,
  input  logic [ENT_AW-1:0]        entities_number,
  output logic [ENT_AW-1:0]        address_read_ent,
  input  logic [3+2*COORD_W-1:0]   data_read_ent,
  output logic [COORD_W-1:0]       address_write_row,
  output logic [23:0]              data_write_row,
  output logic                     wren,
  output logic [COORD_W-1:0]       current_row,
  output logic                     busy,
  output logic                     done
);

  localparam int                 DW         = 3 + 2 * COORD_W;
  localparam logic [COORD_W:0]   L_ENT_DIM  = (COORD_W+1)'(ENT_DIM);
  localparam logic [COORD_W:0]   L_ROW_WID  = (COORD_W+1)'(ROW_WIDTH);
  localparam logic [COORD_W-1:0] L_LAST_ROW = COORD_W'(MAX_ROW - 1);
  localparam logic [COORD_W-1:0] L_LAST_COL = COORD_W'(ROW_WIDTH - 1);
  localparam logic [COORD_W-1:0] L_LAST_PIX = COORD_W'(ENT_DIM - 1);
  localparam logic [2:0]         TYPE_OFF   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_EVAL  = 3'd4,
    S_DRAW  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Type 7 is never drawn, so its palette slot is irrelevant.
  function automatic logic [23:0] palette(input logic [2:0] t);
    logic [23:0] c;
    case (t)
      3'd0:    c = 24'hFF0000;
      3'd1:    c = 24'h00FF00;
      3'd2:    c = 24'h0000FF;
      3'd3:    c = 24'hFFFF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'h00FFFF;
      3'd6:    c = 24'hFFFFFF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  state_t              r_state;
  logic [ENT_AW-1:0]   r_idx;
  logic [COORD_W-1:0]  r_pix;
  logic [COORD_W-1:0]  r_clr;
  logic [COORD_W-1:0]  r_col;
  logic [2:0]          r_type;
  logic [ENT_AW-1:0]   r_addr_ent;
  logic [COORD_W-1:0]  r_addr_row;
  logic [23:0]         r_data_row;
  logic                r_wren;
  logic [COORD_W-1:0]  r_row;
  logic                r_busy;
  logic                r_done;

  logic [2:0]          w_ent_type;
  logic [COORD_W-1:0]  w_ent_row;
  logic [COORD_W-1:0]  w_ent_col;
  logic [COORD_W:0]    w_row_ext;
  logic [COORD_W:0]    w_start_ext;
  logic                w_hit;
  logic [COORD_W:0]    w_pix_col;
  logic                w_pix_vis;
  logic [COORD_W-1:0]  w_next_row;

  assign w_ent_type  = data_read_ent[DW-1 -: 3];
  assign w_ent_row   = data_read_ent[2*COORD_W-1 -: COORD_W];
  assign w_ent_col   = data_read_ent[COORD_W-1:0];

  // One extra bit keeps start_row+ENT_DIM from wrapping, so tall entities clip at the bottom.
  assign w_row_ext   = {1'b0, r_row};
  assign w_start_ext = {1'b0, w_ent_row};
  assign w_hit       = (w_ent_type != TYPE_OFF) &&
                       (w_row_ext >= w_start_ext) &&
                       (w_row_ext < (w_start_ext + L_ENT_DIM));

  assign w_pix_col   = {1'b0, r_col} + {1'b0, r_pix};
  assign w_pix_vis   = (w_pix_col < L_ROW_WID);
  assign w_next_row  = (r_row == L_LAST_ROW) ? {COORD_W{1'b0}} : (r_row + COORD_W'(1));

  // Render sequencer; swap aborts any work in progress and restarts on the next row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= {ENT_AW{1'b0}};
      r_pix      <= {COORD_W{1'b0}};
      r_clr      <= {COORD_W{1'b0}};
      r_col      <= {COORD_W{1'b0}};
      r_type     <= 3'd0;
      r_addr_ent <= {ENT_AW{1'b0}};
      r_addr_row <= {COORD_W{1'b0}};
      r_data_row <= 24'h000000;
      r_wren     <= 1'b0;
      r_row      <= L_LAST_ROW;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (swap) begin
      r_row   <= w_next_row;
      r_wren  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      r_idx   <= {ENT_AW{1'b0}};
      r_clr   <= {COORD_W{1'b0}};
      r_pix   <= {COORD_W{1'b0}};
      r_state <= CLEAR_EN ? S_CLEAR : S_FETCH;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wren <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
        S_CLEAR: begin
          r_addr_row <= r_clr;
          r_data_row <= BG_COLOR;
          r_wren     <= 1'b1;
          if (r_clr == L_LAST_COL) begin
            r_clr   <= {COORD_W{1'b0}};
            r_idx   <= {ENT_AW{1'b0}};
            r_state <= S_FETCH;
          end else begin
            r_clr <= r_clr + COORD_W'(1);
          end
        end
        S_FETCH: begin
          r_wren <= 1'b0;
          if (r_idx >= entities_number) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr_ent <= r_idx;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wren  <= 1'b0;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_wren <= 1'b0;
          r_col  <= w_ent_col;
          r_type <= w_ent_type;
          r_pix  <= {COORD_W{1'b0}};
          if (w_hit) begin
            r_state <= S_DRAW;
          end else begin
            r_idx   <= r_idx + ENT_AW'(1);
            r_state <= S_FETCH;
          end
        end
        // Every pixel slot costs a cycle even when clipped, keeping render time predictable.
        S_DRAW: begin
          r_addr_row <= w_pix_col[COORD_W-1:0];
          r_data_row <= palette(r_type);
          r_wren     <= w_pix_vis;
          if (r_pix == L_LAST_PIX) begin
            r_idx   <= r_idx + ENT_AW'(1);
            r_state <= S_FETCH;
          end else begin
            r_pix <= r_pix + COORD_W'(1);
          end
        end
        S_DONE: begin
          r_wren <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_wren  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign address_read_ent  = r_addr_ent;
  assign address_write_row = r_addr_row;
  assign data_write_row    = r_data_row;
  assign wren              = r_wren;
  assign current_row       = r_row;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

// File: tb/tb_row_renderer_p.sv
// Directed bench for row_renderer_p with a synchronous entity RAM and a row-buffer model.
module tb_row_renderer_p;
  localparam int CW = 10;
  localparam int AW = 8;
  localparam int DW = 3 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          swap;
  logic [AW-1:0] entities_number;
  logic [AW-1:0] address_read_ent;
  logic [DW-1:0] data_read_ent;
  logic [CW-1:0] address_write_row;
  logic [23:0]   data_write_row;
  logic          wren;
  logic [CW-1:0] current_row;
  logic          busy;
  logic          done;

  logic [DW-1:0] ram [0:255];
  logic [23:0]   rowbuf [0:1023];
  int            wr_cnt;
  int            checks = 0;
  int            errors = 0;

  row_renderer_p dut (
    .clk(clk), .rst_n(rst_n), .swap(swap), .entities_number(entities_number),
    .address_read_ent(address_read_ent), .data_read_ent(data_read_ent),
    .address_write_row(address_write_row), .data_write_row(data_write_row),
    .wren(wren), .current_row(current_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) data_read_ent <= ram[address_read_ent];

  always @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt <= 0;
    end else if (wren) begin
      rowbuf[address_write_row] <= data_write_row;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic int count_bad(input int lo, input int hi, input logic [23:0] v);
    int n = 0;
    for (int a = lo; a <= hi; a++) if (rowbuf[a] !== v) n++;
    return n;
  endfunction

  task automatic pulse_swap();
    @(negedge clk) swap = 1'b1;
    @(negedge clk) swap = 1'b0;
  endtask

  task automatic render(output int cyc, output int base);
    pulse_swap();
    base = wr_cnt;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic advance_to(input int target);
    int guard = 0;
    while (current_row != CW'(target) && guard < 1000) begin
      pulse_swap();
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; swap = 1'b0; entities_number = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (current_row !== 10'd479) begin errors++; $display("FAIL reset_row got %0d exp 479", current_row); end
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", wren); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (address_write_row !== 10'd0 || data_write_row !== 24'h0 || address_read_ent !== 8'd0) begin
      errors++; $display("FAIL reset_addr got aw=%0d dw=%h ar=%0d exp 0 0 0", address_write_row, data_write_row, address_read_ent); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_flags got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_empty();
    int cyc, base;
    entities_number = 8'd0;
    pulse_swap();
    checks++; if (current_row !== 10'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL empty_start got row=%0d busy=%b done=%b exp 0 1 0", current_row, busy, done); end
    base = wr_cnt; cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 641) begin errors++; $display("FAIL empty_cycles got %0d exp 641", cyc); end
    checks++; if (wr_cnt - base != 640) begin errors++; $display("FAIL empty_writes got %0d exp 640", wr_cnt - base); end
    checks++; if (count_bad(0, 639, 24'h000000) != 0) begin errors++; $display("FAIL empty_bg got %0d bad exp 0", count_bad(0, 639, 24'h000000)); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL empty_done got busy=%b done=%b exp 0 1", busy, done); end
  endtask

  task automatic test_overlap();
    int cyc, base;
    advance_to(4);
    ram[0] = {3'd0, 10'd0, 10'd50};
    ram[1] = {3'd2, 10'd0, 10'd60};
    ram[2] = {3'd7, 10'd0, 10'd200};
    entities_number = 8'd3;
    render(cyc, base);
    checks++; if (current_row !== 10'd5) begin errors++; $display("FAIL ovl_row got %0d exp 5", current_row); end
    checks++; if (cyc != 746) begin errors++; $display("FAIL ovl_cycles got %0d exp 746", cyc); end
    checks++; if (wr_cnt - base != 736) begin errors++; $display("FAIL ovl_writes got %0d exp 736", wr_cnt - base); end
    checks++; if (count_bad(50, 59, 24'hFF0000) != 0) begin errors++; $display("FAIL ovl_red got %0d bad exp 0", count_bad(50, 59, 24'hFF0000)); end
    checks++; if (count_bad(60, 107, 24'h0000FF) != 0) begin errors++; $display("FAIL ovl_blue got %0d bad exp 0", count_bad(60, 107, 24'h0000FF)); end
    checks++; if (count_bad(0, 49, 24'h0) + count_bad(108, 639, 24'h0) != 0) begin
      errors++; $display("FAIL ovl_bg got %0d bad exp 0", count_bad(0, 49, 24'h0) + count_bad(108, 639, 24'h0)); end
  endtask

  task automatic test_abort();
    int n = 0;
    logic found = 1'b0;
    advance_to(6);
    ram[0] = {3'd3, 10'd0, 10'd300};
    entities_number = 8'd1;
    pulse_swap();
    while (!found && n < 1000) begin
      @(negedge clk); n++;
      if (wren === 1'b1 && address_write_row === 10'd310 && data_write_row === 24'hFFFF00) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL abort_reach_draw got %b exp 1", found); end
    pulse_swap();
    checks++; if (current_row !== 10'd8 || wren !== 1'b0) begin errors++; $display("FAIL abort_swap got row=%0d wren=%b exp 8 0", current_row, wren); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_flags got busy=%b done=%b exp 1 0", busy, done); end
    @(negedge clk);
    checks++; if (wren !== 1'b1 || address_write_row !== 10'd0 || data_write_row !== 24'h0) begin
      errors++; $display("FAIL abort_clear got wren=%b addr=%0d data=%h exp 1 0 000000", wren, address_write_row, data_write_row); end
    n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (rowbuf[300] !== 24'hFFFF00) begin errors++; $display("FAIL abort_rerender got %h exp ffff00", rowbuf[300]); end
  endtask

  task automatic test_hit();
    int cyc, base;
    advance_to(9);
    ram[0] = {3'd1, 10'd0, 10'd100};
    entities_number = 8'd1;
    render(cyc, base);
    checks++; if (current_row !== 10'd10) begin errors++; $display("FAIL hit_row got %0d exp 10", current_row); end
    checks++; if (cyc != 692) begin errors++; $display("FAIL hit_cycles got %0d exp 692", cyc); end
    checks++; if (wr_cnt - base != 688) begin errors++; $display("FAIL hit_writes got %0d exp 688", wr_cnt - base); end
    checks++; if (count_bad(100, 147, 24'h00FF00) != 0) begin errors++; $display("FAIL hit_span got %0d bad exp 0", count_bad(100, 147, 24'h00FF00)); end
    checks++; if (rowbuf[99] !== 24'h0 || rowbuf[148] !== 24'h0) begin errors++; $display("FAIL hit_edges got %h %h exp 000000", rowbuf[99], rowbuf[148]); end
  endtask

  task automatic test_clip();
    int cyc, base;
    advance_to(24);
    ram[0] = {3'd2, 10'd20, 10'd620};
    entities_number = 8'd1;
    render(cyc, base);
    checks++; if (current_row !== 10'd25) begin errors++; $display("FAIL clip_row got %0d exp 25", current_row); end
    checks++; if (cyc != 692) begin errors++; $display("FAIL clip_cycles got %0d exp 692", cyc); end
    checks++; if (wr_cnt - base != 660) begin errors++; $display("FAIL clip_writes got %0d exp 660", wr_cnt - base); end
    checks++; if (count_bad(620, 639, 24'h0000FF) != 0) begin errors++; $display("FAIL clip_span got %0d bad exp 0", count_bad(620, 639, 24'h0000FF)); end
    checks++; if (rowbuf[619] !== 24'h0) begin errors++; $display("FAIL clip_left got %h exp 000000", rowbuf[619]); end
  endtask

  task automatic test_row_edge();
    int cyc, base;
    advance_to(46);
    ram[0] = {3'd1, 10'd0, 10'd100};
    entities_number = 8'd1;
    render(cyc, base);
    checks++; if (wr_cnt - base != 688) begin errors++; $display("FAIL edge47_writes got %0d exp 688", wr_cnt - base); end
    render(cyc, base);
    checks++; if (current_row !== 10'd48) begin errors++; $display("FAIL edge48_row got %0d exp 48", current_row); end
    checks++; if (wr_cnt - base != 640) begin errors++; $display("FAIL edge48_writes got %0d exp 640", wr_cnt - base); end
    checks++; if (cyc != 644) begin errors++; $display("FAIL edge48_cycles got %0d exp 644", cyc); end
    checks++; if (rowbuf[100] !== 24'h0) begin errors++; $display("FAIL edge48_pix got %h exp 000000", rowbuf[100]); end
  endtask

  task automatic test_wrap();
    entities_number = 8'd0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 481; i++) begin
      pulse_swap();
      checks++; if (current_row !== CW'((i - 1) % 480)) begin
        errors++; $display("FAIL wrap_row swap %0d got %0d exp %0d", i, current_row, (i - 1) % 480); end
    end
  endtask

  task automatic test_reset_draw();
    int n = 0;
    logic found = 1'b0;
    ram[0] = {3'd0, 10'd0, 10'd0};
    entities_number = 8'd1;
    pulse_swap();
    while (!found && n < 2000) begin
      @(negedge clk); n++;
      if (wren === 1'b1 && address_write_row === 10'd5 && data_write_row === 24'hFF0000) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstdraw_reach got %b exp 1", found); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstdraw_flags got wren=%b busy=%b done=%b exp 0 0 0", wren, busy, done); end
    checks++; if (current_row !== 10'd479) begin errors++; $display("FAIL rstdraw_row got %0d exp 479", current_row); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {3'd7, 10'd0, 10'd0};
    rst_n = 1'b0; swap = 1'b0; entities_number = 8'd0;
    test_reset();
    test_empty();
    test_overlap();
    test_abort();
    test_hit();
    test_clip();
    test_row_edge();
    test_wrap();
    test_reset_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/row_renderer_p.md
Name: row_renderer_p

Overview:
- Parametrised successor to the per-scanline entity drawer. On each `swap` pulse it advances to the next display row and optionally clears the row buffer to a background colour.
- It then walks the entity table and writes the covering `ENT_DIM`-pixel span of every visible entity into the row buffer.
- Sits between the entity RAM (synchronous read) and the row line buffer that the VGA scan-out reads on the other half of the double buffer.

Parameters:
- ENT_DIM, 48, entity edge length in pixels (square entities).
- MAX_ROW, 480, number of display rows; the row counter wraps at MAX_ROW-1.
- ROW_WIDTH, 640, pixels per row; row-buffer writes at column >= ROW_WIDTH are suppressed.
- COORD_W, 10, width of entity row/column coordinates and of the row-buffer address.
- ENT_AW, 8, entity-table address width.
- CLEAR_EN, 1, when 1 the row buffer is filled with BG_COLOR before entities are drawn.
- BG_COLOR, 24'h000000, background RGB888.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- swap  input  1  single-cycle pulse: start rendering the next row
- entities_number  input  ENT_AW  number of valid table entries (indices 0..n-1)
- address_read_ent  output  ENT_AW  entity RAM read address
- data_read_ent  input  3+2*COORD_W  entity word {type[2:0], start_row[COORD_W-1:0], start_col[COORD_W-1:0]}, valid 1 cycle after address
- address_write_row  output  COORD_W  row-buffer write address
- data_write_row  output  24  row-buffer write data, RGB888
- wren  output  1  row-buffer write enable
- current_row  output  COORD_W  row being rendered
- busy  output  1  high from the cycle after swap until DONE
- done  output  1  high in DONE, cleared by swap

Behaviour:
- Reset (rst_n=0 at posedge) forces:
  - address_read_ent=0, address_write_row=0, data_write_row=0, wren=0, busy=0, done=0.
  - current_row=MAX_ROW-1, so the first swap renders row 0.
  - state=IDLE.
- Swap handling: swap sampled high in any state (including mid-render) aborts the current work.
  - current_row <= (current_row==MAX_ROW-1) ? 0 : current_row+1.
  - wren <= 0, done <= 0, busy <= 1.
  - state <= CLEAR if CLEAR_EN, else FETCH with entity index 0.
  - rst_n has priority over swap.
- CLEAR: one write per cycle, addresses 0..ROW_WIDTH-1, data BG_COLOR, wren=1. After the last address, state <= FETCH with index 0.
- FETCH:
  - If index >= entities_number, go to DONE; entities_number=0 gives DONE directly.
  - Otherwise drive address_read_ent=index, wren=0, and go to WAIT.
- WAIT: one cycle for the RAM read latency, then go to EVAL.
- EVAL: latch data_read_ent fields.
  - Hit condition: type != 7 AND current_row >= start_row AND current_row < start_row+ENT_DIM.
  - All compares are done in COORD_W+1 bits so start_row+ENT_DIM never wraps. Entities extending past MAX_ROW are clipped, not wrapped to row 0.
  - Hit -> DRAW with pixel counter p=0. Miss -> index+1, FETCH.
- DRAW: one pixel per cycle, p=0..ENT_DIM-1.
  - address_write_row=start_col+p (truncated to COORD_W), data_write_row=palette(type).
  - wren=1 only if start_col+p < ROW_WIDTH, compared in COORD_W+1 bits.
  - After p=ENT_DIM-1: index+1, FETCH.
  - Exactly ENT_DIM cycles are spent regardless of clipping.
- Palette (type -> RGB):
  - 0 FF0000, 1 00FF00, 2 0000FF, 3 FFFF00, 4 FF00FF, 5 00FFFF, 6 FFFFFF.
  - 7 = disabled; the entity is skipped.
- Priority: entities are drawn in ascending index, so a later index overwrites overlapping pixels of an earlier one.
- DONE: wren=0, busy=0, done=1. Holds until swap.
- IDLE is only reachable from reset and behaves as DONE without asserting done.
- Render-time bound: CLEAR_EN*ROW_WIDTH + entities_number*3 + hits*ENT_DIM + 1 cycles. The integrator guarantees swap spacing exceeds this bound; if it does not, the abort rule above applies.
- Outputs are registered; wren, address_write_row and data_write_row change together on the same edge.

Test Plan:
- Reset then swap, CLEAR_EN=1, entities_number=0 -> current_row=0; 640 writes of 000000 at addresses 0..639; then done=1, busy=0.
- Row 10, entity0={type 1, row 0, col 100} -> 48 writes of 00FF00 at addresses 100..147. Same entity at row 48 -> no DRAW writes.
- Entity {type 2, row 20, col 620}, row 25 -> addresses 620..639 written with 0000FF; 28 DRAW cycles with wren=0; done after the full 48 cycles.
- Two overlapping entities, idx0 type 0 col 50 and idx1 type 2 col 60, both covering row 5 -> final buffer: 50..59=FF0000, 60..107=0000FF. Type-7 entity -> no writes.
- Swap asserted mid-DRAW at row 7 -> next cycle current_row=8, wren=0, CLEAR restarts at address 0.
- 480 swaps from reset -> current_row wraps 479->0. rst_n low during DRAW -> next cycle wren=0, busy=0, current_row=479.
